// File: rtl/isa_pkg.sv
// isa_pkg: instruction-type/opcode constants and issue-sequencer state shared by the issue block
package isa_pkg;
  localparam logic [1:0] TYPE_MEM  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;
  localparam logic [1:0] TYPE_VEC  = 2'b11;
  localparam logic [4:0] OP_STALL    = 5'b00101;
  localparam logic [4:0] OP_STALL_RD = 5'b00110;
  localparam logic [4:0] OP_STALL_WR = 5'b00111;
  localparam logic [1:0] SUB_LOAD   = 2'b00;
  localparam logic [1:0] SUB_STORE  = 2'b01;
  localparam logic [1:0] SUB_VLOAD  = 2'b10;
  localparam logic [1:0] SUB_VSTORE = 2'b11;
  typedef enum logic [1:0] {ST_ISSUE, ST_VREAD, ST_VWRITE, ST_BUBBLE} issue_state_t;
  function automatic int cnt_w(input int vec_beats, input int br_bubbles);
    int m;
    m = vec_beats > br_bubbles + 1 ? vec_beats : br_bubbles + 1;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/beat_counter.sv
// beat_counter: loadable down-counter flagging the final beat of an expansion
module beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;
  // load on a new expansion, otherwise count down once per advancing slot
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/instr_issue_seq.sv
// instr_issue_seq: issues fetched instructions to decode, expanding vector mem ops (and branches with ISSUE_BRANCH_BUBBLE_EN)
module instr_issue_seq
  import isa_pkg::*;
#(
  parameter int VEC_BEATS  = 4,
  parameter int BR_BUBBLES = 2,
  parameter int FIELD_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_type,
  input  logic [4:0]         in_opcode,
  input  logic [FIELD_W-1:0] in_fields,
  input  logic               out_ready,
  input  logic               flush,
  output logic [1:0]         instruction_type,
  output logic [4:0]         opcode,
  output logic [FIELD_W-1:0] out_fields,
  output logic               busy
);
  localparam int CW = cnt_w(VEC_BEATS, BR_BUBBLES);
  localparam logic [CW-1:0] VEC_LOAD = CW'(VEC_BEATS - 1);
  issue_state_t state;
  logic flush_pend, cnt_last, is_vec, go_vec, go_bub;
  logic [CW-1:0] cnt_init;
  assign in_ready = rst && out_ready && state == ST_ISSUE && !flush && !flush_pend;
  assign is_vec = in_type == TYPE_MEM && (in_opcode[4:3] == SUB_VLOAD || in_opcode[4:3] == SUB_VSTORE);
  assign go_vec = VEC_BEATS > 1 && is_vec;
`ifdef ISSUE_BRANCH_BUBBLE_EN
  assign go_bub = BR_BUBBLES > 0 && in_type == TYPE_CTRL;
  assign cnt_init = go_vec ? VEC_LOAD : CW'(BR_BUBBLES);
`else
  assign go_bub = 1'b0;
  assign cnt_init = VEC_LOAD;
`endif
  assign busy = state != ST_ISSUE;
  beat_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (in_ready && in_valid && (go_vec || go_bub)),
    .en       (out_ready && state != ST_ISSUE),
    .load_val (cnt_init),
    .last     (cnt_last)
  );
  // issue FSM: one output slot per advancing edge; flush inside a vector expansion is deferred
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state            <= ST_ISSUE;
      flush_pend       <= 1'b0;
      instruction_type <= TYPE_DATA;
      opcode           <= OP_STALL;
      out_fields       <= '0;
    end else if (out_ready) begin
      case (state)
        ST_ISSUE:
          if (flush || flush_pend) begin
            instruction_type <= TYPE_DATA;
            opcode           <= OP_STALL;
            flush_pend       <= 1'b0;
          end else if (in_valid) begin
            instruction_type <= in_type;
            opcode           <= in_opcode;
            out_fields       <= in_fields;
            state            <= go_vec ? (in_opcode[3] ? ST_VWRITE : ST_VREAD) : go_bub ? ST_BUBBLE : ST_ISSUE;
          end else begin
            instruction_type <= TYPE_DATA;
            opcode           <= OP_STALL;
          end
        ST_VREAD, ST_VWRITE: begin
          instruction_type <= TYPE_DATA;
          opcode           <= state == ST_VREAD ? OP_STALL_RD : OP_STALL_WR;
          if (flush) flush_pend <= 1'b1;
          if (cnt_last) state <= ST_ISSUE;
        end
`ifdef ISSUE_BRANCH_BUBBLE_EN
        ST_BUBBLE: begin
          instruction_type <= TYPE_DATA;
          opcode           <= OP_STALL;
          if (flush || cnt_last) state <= ST_ISSUE;
        end
`endif
        default: state <= ST_ISSUE;
      endcase
    end
endmodule

// File: tb/tb_instr_issue_seq.sv
// tb_instr_issue_seq: randomized and directed checks of instr_issue_seq against a slot-queue reference model
module tb_instr_issue_seq;
  localparam int VB = 4;
  localparam int BB = 2;
  localparam int FW = 20;
`ifdef ISSUE_BRANCH_BUBBLE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [1:0] in_type = '0;
  logic [4:0] in_opcode = '0;
  logic [FW-1:0] in_fields = '0;
  logic in_ready, busy;
  logic [1:0] instruction_type;
  logic [4:0] opcode;
  logic [FW-1:0] out_fields;
  always #5 clk = ~clk;
  instr_issue_seq #(.VEC_BEATS(VB), .BR_BUBBLES(BB), .FIELD_W(FW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_fields(in_fields), .out_ready(out_ready), .flush(flush),
    .instruction_type(instruction_type), .opcode(opcode), .out_fields(out_fields), .busy(busy)
  );
  typedef struct {logic [1:0] t; logic [4:0] op; bit bub;} slot_t;
  slot_t q[$];
  bit pend, exp_fchk, exp_rdy, got_rdy, exp_busy;
  logic [1:0] exp_t;
  logic [4:0] exp_op;
  logic [FW-1:0] exp_f;
  int checks = 0, errors = 0, cyc = 0;
  function automatic bit model_ready();
    return rst && out_ready && q.size() == 0 && !flush && !pend;
  endfunction
  task automatic model_reset();
    q.delete();
    pend = 0; exp_t = 2'b01; exp_op = 5'b00101; exp_f = '0; exp_fchk = 1; exp_busy = 0;
  endtask
  task automatic model_step();
    slot_t s;
    if (q.size() > 0) begin
      s = q.pop_front();
      exp_t = s.t; exp_op = s.op; exp_fchk = !s.bub;
      if (flush) begin
        if (s.bub) q.delete();
        else pend = 1;
      end
    end else if (flush || pend) begin
      exp_t = 2'b01; exp_op = 5'b00101; exp_fchk = 0; pend = 0;
    end else if (in_valid) begin
      exp_t = in_type; exp_op = in_opcode; exp_f = in_fields; exp_fchk = 1;
      if (in_type == 2'b00 && in_opcode[4] && VB > 1) begin
        s.t = 2'b01; s.op = in_opcode[3] ? 5'b00111 : 5'b00110; s.bub = 0;
        repeat (VB - 1) q.push_back(s);
      end else if (FEAT && in_type == 2'b10) begin
        s.t = 2'b01; s.op = 5'b00101; s.bub = 1;
        repeat (BB) q.push_back(s);
      end
    end else begin
      exp_t = 2'b01; exp_op = 5'b00101; exp_fchk = 0;
    end
    exp_busy = q.size() != 0;
  endtask
  task automatic tick();
    #1;
    exp_rdy = model_ready();
    got_rdy = in_ready;
    @(posedge clk);
    if (rst && out_ready) model_step();
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (instruction_type !== 2'b01 || opcode !== 5'b00101 || out_fields !== '0 || busy !== 0 || in_ready !== 0) begin
      errors++;
      $display("FAIL reset: got t=%b op=%b f=%h busy=%b rdy=%b want t=01 op=00101 f=0 busy=0 rdy=0", instruction_type, opcode, out_fields, busy, in_ready);
    end
    rst = 1;
  endtask
  task automatic test_idle();
    repeat (4) begin
      tick();
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL idle cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
    end
  endtask
  task automatic test_scalar();
    in_valid = 1; in_type = 2'b01; in_opcode = 5'b00000; in_fields = 20'h12345;
    tick();
    in_valid = 0;
    checks++;
    if (instruction_type !== 2'b01 || opcode !== 5'b00000 || out_fields !== 20'h12345 || got_rdy !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL scalar: got t=%b op=%b f=%h rdy=%b busy=%b want t=01 op=00000 f=12345 rdy=1 busy=0", instruction_type, opcode, out_fields, got_rdy, busy);
    end
    tick();
    checks++;
    if (in_ready !== 1 || opcode !== exp_op || busy !== exp_busy) begin
      errors++;
      $display("FAIL scalar_after: got rdy=%b op=%b busy=%b want rdy=1 op=%b busy=%b", in_ready, opcode, busy, exp_op, exp_busy);
    end
  endtask
  task automatic test_vload();
    int nbeat = 0;
    in_valid = 1; in_type = 2'b00; in_opcode = 5'b10000; in_fields = FW'($urandom);
    tick();
    in_valid = 0;
    repeat (VB + 1) begin
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL vload cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
      if (instruction_type == 2'b01 && opcode == 5'b00110) nbeat++;
      tick();
    end
    checks++;
    if (nbeat !== VB - 1) begin
      errors++;
      $display("FAIL vload_beats: got %0d want %0d", nbeat, VB - 1);
    end
  endtask
  task automatic test_vstore_stall();
    int nbeat = 0;
    in_valid = 1; in_type = 2'b00; in_opcode = 5'b11010; in_fields = FW'($urandom);
    tick();
    in_valid = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = !(i == 2 || i == 3);
      tick();
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL vstore_stall cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
      if (out_ready && instruction_type == 2'b01 && opcode == 5'b00111) nbeat++;
    end
    out_ready = 1;
    checks++;
    if (nbeat !== VB - 1) begin
      errors++;
      $display("FAIL vstore_beats: got %0d want %0d", nbeat, VB - 1);
    end
  endtask
  task automatic test_flush_vread();
    int acc_at = -1;
    in_valid = 1; in_type = 2'b00; in_opcode = 5'b10011; in_fields = FW'($urandom);
    tick();
    in_valid = 0;
    tick();
    in_valid = 1; in_type = 2'b01; in_opcode = 5'b00010; in_fields = FW'($urandom); flush = 1;
    tick();
    flush = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL flush_vread cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
      if (acc_at < 0 && opcode == 5'b00010) acc_at = i;
      if (exp_rdy) in_valid = 0;
    end
    checks++;
    if (acc_at !== VB - 1) begin
      errors++;
      $display("FAIL flush_vread_slot: got %0d want %0d", acc_at, VB - 1);
    end
  endtask
  task automatic test_branch();
    int acc_at;
    for (int f = 0; f < 2; f++) begin
      acc_at = -1;
      in_valid = 1; in_type = 2'b10; in_opcode = 5'b01000; in_fields = FW'($urandom);
      tick();
      in_type = 2'b01; in_opcode = 5'b00001; in_fields = FW'($urandom);
      for (int i = 1; i <= BB + 3; i++) begin
        flush = f == 1 && i == 1;
        tick();
        checks++;
        if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
          errors++;
          $display("FAIL branch%0d cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", f, cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
        end
        if (acc_at < 0 && opcode == 5'b00001) acc_at = i;
        if (exp_rdy) in_valid = 0;
      end
      flush = 0;
      checks++;
      if (acc_at !== (f == 1 ? 2 : (FEAT ? BB + 1 : 1))) begin
        errors++;
        $display("FAIL branch%0d_slot: got %0d want %0d", f, acc_at, f == 1 ? 2 : (FEAT ? BB + 1 : 1));
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 9) < 6;
      in_type = 2'($urandom);
      in_opcode = 5'($urandom);
      in_fields = FW'($urandom);
      out_ready = $urandom_range(0, 99) < 85;
      flush = $urandom_range(0, 99) < 8;
      if (i >= 390) begin in_valid = 0; flush = 0; out_ready = 1; end
      tick();
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL random cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
    end
  endtask
  task automatic test_async_reset();
    in_valid = 1; in_type = 2'b00; in_opcode = 5'b10001; in_fields = FW'($urandom);
    tick();
    in_valid = 0;
    tick();
    #2;
    rst = 0;
    #1;
    model_reset();
    checks++;
    if (instruction_type !== 2'b01 || opcode !== 5'b00101 || out_fields !== '0 || busy !== 0 || in_ready !== 0) begin
      errors++;
      $display("FAIL async_reset: got t=%b op=%b f=%h busy=%b rdy=%b want t=01 op=00101 f=0 busy=0 rdy=0", instruction_type, opcode, out_fields, busy, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1;
    repeat (3) begin
      tick();
      checks++;
      if (instruction_type !== exp_t || opcode !== exp_op || busy !== exp_busy || got_rdy !== exp_rdy || (exp_fchk && out_fields !== exp_f)) begin
        errors++;
        $display("FAIL after_reset cyc=%0d: got t=%b op=%b f=%h busy=%b rdy=%b want t=%b op=%b f=%h busy=%b rdy=%b", cyc, instruction_type, opcode, out_fields, busy, got_rdy, exp_t, exp_op, exp_f, exp_busy, exp_rdy);
      end
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_scalar();
    test_vload();
    test_vstore_stall();
    test_flush_vread();
    test_branch();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
